clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel programmable clock-enable generator for the lab designs' slow-logic domains (display scan, debounce, counters). Each of NCH channels divides clk by an independently programmed integer divisor and produces a one-cycle tick plus a registered near-50% square wave. Divisors are loaded at run time through a valid/ready port and take effect only at a period boundary, so no channel ever emits a runt pulse.

## Interface
- NCH, 4: number of channels (1..16)
- DIV_W, 16: divisor width in bits
- DEF_DIV, 2: divisor loaded into every channel at reset (0 < DEF_DIV < 2^DIV_W)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  NCH  per-channel run enable
- cfg_valid  in  1  divisor write request
- cfg_ready  out  1  write accepted when valid & ready at a clk edge
- cfg_ch  in  $clog2(NCH) (min 1)  target channel
- cfg_div  in  DIV_W  new divisor D
- cfg_err  out  1  one-cycle pulse: write addressed a channel ≥ NCH
- tick  out  NCH  one-cycle enable pulse per period
- clk_out  out  NCH  divided square wave, registered
- busy  out  NCH  channel has a pending divisor not yet applied

## Operation
- Per channel: active divisor act_d, pending divisor pend_d, pending flag pend, counter cnt (DIV_W bits).
- Reset: act_d=DEF_DIV, pend=0, cnt=0; tick=0, clk_out=0, busy=0, cfg_err=0, cfg_ready=1.
- en[i]=0: cnt held at 0, tick[i]=0, clk_out[i]=0 from next edge. Pending update applied immediately (next edge).
- en[i]=1, act_d≥2: cnt counts 0..act_d-1 and wraps to 0; tick[i] <= (cnt==act_d-1); clk_out[i] <= (cnt < floor(act_d/2)). High time floor(D/2), low time ceil(D/2) cycles.
- act_d=1: tick[i]=1 continuously, clk_out[i]=1 continuously while enabled.
- act_d=0: channel stopped; outputs 0, cnt held at 0, regardless of en.
- Write accepted (cfg_valid & cfg_ready): pend_d=cfg_div, pend=1. cfg_ready = ~pend[cfg_ch] combinationally, for in-range cfg_ch; always 1 for out-of-range cfg_ch.
- Out-of-range write: data dropped, cfg_err high the following cycle only.
- Pending apply: at the edge where cnt wraps (cnt==act_d-1, enabled), or next edge if channel disabled/stopped/act_d=1; act_d<=pend_d, cnt<=0, pend<=0. New period starts at cnt=0 on that same edge.
- Write to a channel with pend=1 is stalled (cfg_ready low), never overwrites.
- busy[i]=pend[i].

## Timing
- en[i] first sampled high at edge E1 (cnt=0): clk_out rises after E1; tick first high during the cycle following edge E1+D-1 (i.e. after D edges), then every D cycles.
- tick and clk_out are flops; no combinational path from any input to them.
- cfg_ready depends combinationally on cfg_ch only.
- Divisor change latency: ≤ act_d cycles enabled; 1 cycle disabled.
- Same-edge en fall and period wrap: disable wins; pending still applied.
- rst mid-operation: all state returns to reset values asynchronously; pending writes lost.

## Configuration
- CLK_DIV_ALIGN_EN defined: adds input align (1 bit). align sampled high at an edge: all channels' cnt<=0 on that edge, any pending divisors applied simultaneously, tick suppressed that cycle; enabled channels are thereafter phase-aligned (first tick D edges later).
- Undefined: no align port; channels run with independent phase.

## Test plan
- Reset, en=all 1, DEF_DIV=2 -> every channel tick high every 2nd cycle, clk_out 1-high/1-low, busy=0.
- Write ch1 D=5 while running D=2 -> busy[1]=1 until next wrap, then tick[1] every 5 cycles, clk_out[1] 2 high/3 low, no pulse shorter than 2 cycles.
- Second write to ch1 while busy[1]=1 -> cfg_ready=0 until apply; value not lost, applied after first.
- NCH=3, write cfg_ch=3 -> cfg_err one cycle, no channel changes.
- D=0 and D=1 on ch0 -> D=0: tick/clk_out stay 0; D=1: tick and clk_out constant 1.
- Assert rst mid-period with pending write -> outputs 0 immediately, act_d=DEF_DIV, busy=0; with CLK_DIV_ALIGN_EN, align pulse -> all enabled ticks coincide D cycles later.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: NCH independent programmable clock-enable dividers.
// Each channel outputs a one-cycle tick and a registered square wave.
// A new divisor is written through a valid/ready port. It is held as
// pending and takes effect only at a period boundary, so no channel
// ever emits a runt pulse.
// Optional feature: define CLK_DIV_ALIGN_EN to add the `align` input.
// When align is high at an edge, all channel counters restart together.

module clk_div_ch #(
   parameter int DIV_W   = 16,
   parameter int DEF_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             align,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             tick,
   output logic             clk_out,
   output logic             busy
);

   logic [DIV_W-1:0] act_d, pend_d, cnt;
   logic             pend;
   logic             run, wrap, apply;

   // A stopped channel (act_d == 0) never runs, whatever en says.
   // When act_d == 1 the counter sits at 0, so every enabled edge is a
   // wrap edge.
   assign run   = en && (act_d != '0);
   assign wrap  = run && (cnt == act_d - 1'b1);
   assign apply = pend && (align || !run || wrap);
   assign busy  = pend;

   // Counter, divisor handoff at the period boundary, and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_d   <= DIV_W'(DEF_DIV);
         pend_d  <= '0;
         pend    <= 1'b0;
         cnt     <= '0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
      end else begin
         // A write is only ever accepted while pend is low, so it
         // cannot collide with an apply on the same edge.
         if (wr) begin
            pend_d <= wr_div;
            pend   <= 1'b1;
         end else if (apply) begin
            act_d <= pend_d;
            pend  <= 1'b0;
         end
         if (apply || align || wrap || !run)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         // These outputs describe the old period, even on an apply edge.
         tick    <= wrap && !align;
         clk_out <= run && ((act_d == DIV_W'(1)) || (cnt < (act_d >> 1)));
      end
   end

endmodule

module clk_div_bank #(
   parameter int NCH     = 4,
   parameter int DIV_W   = 16,
   parameter int DEF_DIV = 2,
   localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en,
`ifdef CLK_DIV_ALIGN_EN
   input  logic             align,
`endif
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_err,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   clk_out,
   output logic [NCH-1:0]   busy
);

   logic in_range;
   logic align_i;

`ifdef CLK_DIV_ALIGN_EN
   assign align_i = align;
`else
   assign align_i = 1'b0;
`endif

   assign in_range = (32'(cfg_ch) < 32'(NCH));

   // Stall only a write aimed at a channel that already holds a pending
   // divisor. Out-of-range writes are always accepted, then dropped.
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NCH; i++)
         if (cfg_ch == CH_W'(i) && busy[i])
            cfg_ready = 1'b0;
   end

   // One-cycle error pulse for a write to a channel that does not exist
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cfg_err <= 1'b0;
      else
         cfg_err <= cfg_valid && !in_range;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      clk_div_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch (
         .clk     (clk),
         .rst     (rst),
         .en      (en[i]),
         .align   (align_i),
         .wr      (cfg_valid && cfg_ready && (cfg_ch == CH_W'(i))),
         .wr_div  (cfg_div),
         .tick    (tick[i]),
         .clk_out (clk_out[i]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank.
// The bench uses NCH=3, so cfg_ch=3 is a real out-of-range address.
// Inputs change on the falling edge and outputs are sampled there too.

module tb_clk_div_bank;

   localparam int NCH   = 3;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NCH-1:0]   en = '0;
   logic             align = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [1:0]       cfg_ch = '0;
   logic [DIV_W-1:0] cfg_div = '0;
   logic             cfg_err;
   logic [NCH-1:0]   tick, clk_out, busy;

   int n_chk = 0;
   int n_pass = 0;
   int n;

   clk_div_bank #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(2)) dut (
      .clk(clk), .rst(rst), .en(en),
`ifdef CLK_DIV_ALIGN_EN
      .align(align),
`endif
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_err(cfg_err), .tick(tick),
      .clk_out(clk_out), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one clock edge and land on the following falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_clk_out", 32'(clk_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      chk("rst_cfg_ready", 32'(cfg_ready), 1);
      rst = 1'b0;
      step();

      // DEF_DIV=2 on all channels
      en = 3'b111;
      step();                                  // E1
      chk("d2_e1_tick", 32'(tick), 32'b000);
      chk("d2_e1_clk", 32'(clk_out), 32'b111);
      step();                                  // E2
      chk("d2_e2_tick", 32'(tick), 32'b111);
      chk("d2_e2_clk", 32'(clk_out), 32'b000);
      step();                                  // E3
      chk("d2_e3_tick", 32'(tick), 32'b000);
      chk("d2_e3_busy", 32'(busy), 32'b000);

      // Write ch1 D=5 while running; applied at the next wrap (E6)
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
      #1 chk("w5_ready", 32'(cfg_ready), 1);
      step();                                  // E4 accept
      cfg_valid = 1'b0;
      chk("w5_busy_e4", 32'(busy), 32'b010);
      step();                                  // E5
      chk("w5_busy_e5", 32'(busy), 32'b010);
      step();                                  // E6 apply
      chk("w5_busy_e6", 32'(busy), 32'b000);
      chk("w5_tick_e6", 32'(tick[1]), 1);
      begin
         logic [4:0] exp_tick, exp_clk;
         exp_tick = 5'b10000;                  // bit k = sample after E7+k
         exp_clk  = 5'b00011;
         for (int k = 0; k < 5; k++) begin
            step();
            chk("d5_tick", 32'(tick[1]), 32'(exp_tick[k]));
            chk("d5_clk", 32'(clk_out[1]), 32'(exp_clk[k]));
         end
      end

      // Two back-to-back writes to ch1: 3 then 4 (second stalls)
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3;
      step();                                  // E12 accept D=3
      cfg_div = 16'd4;
      chk("stall_ready", 32'(cfg_ready), 0);
      n = 0;
      while (!cfg_ready && n < 20) begin
         step();
         n++;
      end
      chk("stall_cycles", 32'(n), 4);
      step();                                  // accept D=4
      cfg_valid = 1'b0;
      chk("w4_busy", 32'(busy[1]), 1);
      chk("w4_tick0", 32'(tick[1]), 0);
      step();
      chk("w4_tick1", 32'(tick[1]), 0);
      step();                                  // D=3 wrap, D=4 applied
      chk("w4_tick2", 32'(tick[1]), 1);
      chk("w4_busy_clr", 32'(busy[1]), 0);
      begin
         logic [3:0] exp_tick;
         exp_tick = 4'b1000;
         for (int k = 0; k < 4; k++) begin
            step();
            chk("d4_tick", 32'(tick[1]), 32'(exp_tick[k]));
         end
      end

      // Out-of-range write
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7;
      #1 chk("oor_ready", 32'(cfg_ready), 1);
      step();
      cfg_valid = 1'b0;
      chk("oor_err", 32'(cfg_err), 1);
      chk("oor_busy", 32'(busy), 0);
      step();
      chk("oor_err_clr", 32'(cfg_err), 0);

      // ch0 D=0: stopped
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd0;
      step();
      cfg_valid = 1'b0;
      step(); step(); step();
      for (int k = 0; k < 3; k++) begin
         chk("d0_tick", 32'(tick[0]), 0);
         chk("d0_clk", 32'(clk_out[0]), 0);
         step();
      end
      // ch0 D=1: constant high
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd1;
      step();
      cfg_valid = 1'b0;
      step(); step();
      for (int k = 0; k < 3; k++) begin
         chk("d1_tick", 32'(tick[0]), 1);
         chk("d1_clk", 32'(clk_out[0]), 1);
         step();
      end

      // Disable ch2: outputs drop and a pending write is applied on the next edge
      en = 3'b011;
      step();
      chk("dis_tick", 32'(tick[2]), 0);
      chk("dis_clk", 32'(clk_out[2]), 0);
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd3;
      step();
      cfg_valid = 1'b0;
      chk("dis_busy_set", 32'(busy[2]), 1);
      step();
      chk("dis_busy_clr", 32'(busy[2]), 0);

      // Reset mid-period with a write pending on ch1 (act_d=4)
      en = 3'b111;
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd9;
      step();
      cfg_valid = 1'b0;
      chk("pre_rst_busy", 32'(busy[1]), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_tick", 32'(tick), 0);
      chk("arst_clk", 32'(clk_out), 0);
      chk("arst_busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      step();                                  // E1 after reset, DEF_DIV everywhere
      chk("post_rst_tick1", 32'(tick), 32'b000);
      chk("post_rst_clk1", 32'(clk_out), 32'b111);
      step();
      chk("post_rst_tick2", 32'(tick), 32'b111);
      chk("post_rst_clk2", 32'(clk_out), 32'b000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
